proc_run_ctrl: RTL and testbench

Run controller for the single-cycle processor. Loads a program byte-by-byte into the processor's instruction memory through a valid/ready handshake. It then holds the core in reset for one cycle, releases it, and lets it run. It stops the core on a halt opcode or a cycle budget, and exposes the executed-cycle count for the test harness.

---
 rtl/proc_run_ctrl.sv | 137 +++++++++++++
 tb/tb_proc_run_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle processor: loads the program, pulses the core reset, runs and stops it.
// Optional `PROC_STEP_EN adds step_mode/step ports for single-instruction stepping.
module proc_run_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter logic [7:0]  HALT_OP = 8'hFF,
  parameter int unsigned MAX_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic              start,
  input  logic              clr,
  input  logic [7:0]        instr,
`ifdef PROC_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_rst_n,
  output logic              core_clk_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cyc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_HALT
  } state_e;

  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYC);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               full;
  logic               run_en;
  logic [CNT_W-1:0]   cnt_inc;

  // The pointer never passes 2^ADDR_W, so its top bit alone marks a full memory.
  assign full = ptr_q[ADDR_W];

`ifdef PROC_STEP_EN
  assign run_en = step_mode ? step : 1'b1;
`else
  assign run_en = 1'b1;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    ld_ready    = (state_q == ST_IDLE) && !full;
    imem_we     = ld_valid && ld_ready;
    imem_addr   = ptr_q[ADDR_W-1:0];
    imem_wdata  = ld_data;
    // Gating with reset makes the core reset follow ours without waiting for a clock.
    core_rst_n  = reset && ((state_q == ST_RUN) || (state_q == ST_HALT));
    core_clk_en = (state_q == ST_RUN) && run_en;
    busy        = (state_q == ST_ARM) || (state_q == ST_RUN);
    done        = (state_q == ST_HALT);
    timeout     = timeout_q;
    cyc_cnt     = cnt_q;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    ptr_d     = imem_we ? ptr_q + (ADDR_W+1)'(1) : ptr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ARM;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_ARM: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (core_clk_en) begin
          cnt_d = cnt_inc;
          // A halt opcode takes priority over an exhausted budget in the same cycle.
          if (instr == HALT_OP) begin
            state_d   = ST_HALT;
            timeout_d = 1'b0;
          end else if (cnt_inc == CYC_LIMIT) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (clr) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else if (start) begin
          state_d   = ST_ARM;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: directed scenarios plus randomized traffic against
// a run-outcome model that predicts each run's end from the loaded program.
module tb_proc_run_ctrl;

  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 16;
  localparam int MAX_CYC = 20;
  localparam int DEPTH   = 16;
  localparam logic [7:0] HALT_OP = 8'hFF;

  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_HALT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic start = 1'b0;
  logic clr = 1'b0;
  logic [7:0] instr;
  logic step_mode = 1'b0;
  logic step = 1'b0;

  logic              ld_ready, imem_we, core_rst_n, core_clk_en, busy, done, timeout;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic [CNT_W-1:0]  cyc_cnt;

  int total = 0;
  int bad = 0;

  proc_run_ctrl #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .HALT_OP(HALT_OP), .MAX_CYC(MAX_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .clr(clr), .instr(instr),
`ifdef PROC_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .core_clk_en(core_clk_en),
    .busy(busy), .done(done), .timeout(timeout), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase = P_IDLE;
  int          m_ptr = 0;
  int          m_cnt = 0;
  int          m_pc = 0;
  int          m_goal = 0;
  bit          m_to = 1'b0;
  bit          m_goal_to = 1'b0;
  logic [7:0]  m_mem [DEPTH] = '{default: 8'h00};

  // The bench plays the instruction memory; the core fetches linearly from address 0 after reset.
  assign instr = m_mem[m_pc % DEPTH];

  function automatic bit model_en();
`ifdef PROC_STEP_EN
    return (m_phase == P_RUN) && (!step_mode || step);
`else
    return (m_phase == P_RUN);
`endif
  endfunction

  function automatic bit exp_ready();
    return (m_phase == P_IDLE) && (m_ptr < DEPTH);
  endfunction

  // Executed-instruction number (1-based) of the first halt opcode, or MAX_CYC+1 if the budget expires first.
  function automatic int first_halt();
    for (int i = 1; i <= MAX_CYC; i++)
      if (m_mem[(i-1) % DEPTH] == HALT_OP) return i;
    return MAX_CYC + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE;
      m_ptr   <= 0;
      m_cnt   <= 0;
      m_to    <= 1'b0;
      m_pc    <= 0;
    end else begin
      if (ld_valid && exp_ready()) begin
        m_mem[m_ptr] <= ld_data;
        m_ptr        <= m_ptr + 1;
      end
      case (m_phase)
        P_IDLE: if (start) begin m_phase <= P_ARM; m_cnt <= 0; m_to <= 1'b0; end
        P_ARM: begin
          m_phase   <= P_RUN;
          m_pc      <= 0;
          m_goal    <= (first_halt() <= MAX_CYC) ? first_halt() : MAX_CYC;
          m_goal_to <= (first_halt() > MAX_CYC);
        end
        P_RUN: if (model_en()) begin
          m_cnt <= m_cnt + 1;
          m_pc  <= m_pc + 1;
          if (m_cnt + 1 == m_goal) begin m_phase <= P_HALT; m_to <= m_goal_to; end
        end
        default: begin
          if (clr) begin m_phase <= P_IDLE; m_ptr <= 0; end
          else if (start) begin m_phase <= P_ARM; m_cnt <= 0; m_to <= 1'b0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("ld_ready", 32'(ld_ready), 32'(exp_ready()));
    check("imem_we", 32'(imem_we), 32'(ld_valid && exp_ready()));
    if (ld_valid && exp_ready()) begin
      check("imem_addr", 32'(imem_addr), 32'(m_ptr % DEPTH));
      check("imem_wdata", 32'(imem_wdata), 32'(ld_data));
    end
    check("core_rst_n", 32'(core_rst_n), 32'((m_phase == P_RUN) || (m_phase == P_HALT)));
    check("core_clk_en", 32'(core_clk_en), 32'(model_en()));
    check("busy", 32'(busy), 32'((m_phase == P_ARM) || (m_phase == P_RUN)));
    check("done", 32'(done), 32'(m_phase == P_HALT));
    check("cyc_cnt", 32'(cyc_cnt), 32'(m_cnt));
    check("timeout", 32'(timeout), 32'(m_to));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] no_halt_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == HALT_OP) b = 8'h00;
    return b;
  endfunction

  task automatic load_bytes(input int n, input int halt_idx, output int we_seen);
    we_seen = 0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = (i == halt_idx) ? HALT_OP : no_halt_byte();
      #1;
      if (imem_we) we_seen++;
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_within_bound", 32'(done), 32'd1);
  endtask

  // Pulses start and returns the number of cycles until done and how many of them had the core in reset.
  task automatic run(input int budget, output int n, output int lowc);
    start = 1'b1;
    n = 0;
    lowc = 0;
    while (!done || n == 0) begin
      tick();
      n++;
      start = 1'b0;
      if (n == 1) begin
        check("arm_cnt_clear", 32'(cyc_cnt), 32'd0);
        check("arm_to_clear", 32'(timeout), 32'd0);
      end
      if (!core_rst_n) lowc++;
      if (n >= budget) break;
    end
    check("run_within_bound", 32'(done), 32'd1);
  endtask

  initial begin
    int we_seen, n, lowc, enc;

    #2 reset = 1'b0;
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_clk_en", 32'(core_clk_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b1;
    tick();

    // 17 bytes back-to-back, halt opcode at program index 4; the 17th must be refused.
    load_bytes(17, 4, we_seen);
    check("load_we_pulses", 32'(we_seen), 32'd16);
    check("full_not_ready", 32'(ld_ready), 32'd0);

    run(100, n, lowc);
    check("halt5_latency", 32'(n), 32'd7);
    check("halt5_rst_low_cycles", 32'(lowc), 32'd1);
    check("halt5_cyc_cnt", 32'(cyc_cnt), 32'd5);
    check("halt5_timeout", 32'(timeout), 32'd0);
    check("halt5_clk_en", 32'(core_clk_en), 32'd0);

    // clr and start together: clr wins.
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    check("clr_done", 32'(done), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    #1;
    check("clr_ptr_zero", 32'(imem_addr), 32'd0);
    ld_valid = 1'b0;

    // Program with no halt opcode: runs to the budget, twice.
    load_bytes(16, -1, we_seen);
    run(100, n, lowc);
    check("budget_latency", 32'(n), 32'(MAX_CYC + 2));
    check("budget_cyc_cnt", 32'(cyc_cnt), 32'd20);
    check("budget_timeout", 32'(timeout), 32'd1);
    run(100, n, lowc);
    check("rerun_cyc_cnt", 32'(cyc_cnt), 32'd20);
    check("rerun_timeout", 32'(timeout), 32'd1);

    // Asynchronous reset in the 7th run cycle.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    load_bytes(3, -1, we_seen);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_reset_cnt", 32'(cyc_cnt), 32'd6);
    #2 reset = 1'b0;
    #1;
    check("async_core_rst_n", 32'(core_rst_n), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_cyc_cnt", 32'(cyc_cnt), 32'd0);
    check("async_idle_ready", 32'(ld_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

`ifdef PROC_STEP_EN
    // Stepped run: three step pulses spread over ten cycles.
    step_mode = 1'b1;
    step = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    enc = 0;
    for (int i = 0; i < 10; i++) begin
      step = (i == 1 || i == 4 || i == 8);
      #1;
      if (core_clk_en) enc++;
      tick();
    end
    step = 1'b0;
    check("step_clk_en_cycles", 32'(enc), 32'd3);
    check("step_cyc_cnt", 32'(cyc_cnt), 32'd3);
    step_mode = 1'b0;
    wait_done(100, n);
    clr = 1'b1;
    tick();
    clr = 1'b0;
`else
    enc = 0;
`endif

    // Randomized traffic; the model tracks every cycle.
    for (int c = 0; c < 1500; c++) begin
      ld_valid  = ($urandom_range(0, 1) == 1);
      ld_data   = ($urandom_range(0, 5) == 0) ? HALT_OP : 8'($urandom);
      start     = ($urandom_range(0, 9) == 0);
      clr       = ($urandom_range(0, 7) == 0);
      step_mode = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 1) == 1);
      tick();
    end
    ld_valid = 1'b0; start = 1'b0; clr = 1'b0; step_mode = 1'b0; step = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
